int_rx_dec: RTL and testbench
=============================

# int_rx_dec

Receive-side companion of the BIP UART interface. Pops ASCII characters from the RX FIFO, parses decimal digit strings terminated by CR/LF/space, and converts them to an NBIT-bit binary operand for the BIP/ALU. It holds that operand under a valid/ack handshake. Malformed or out-of-range numbers raise a one-cycle error pulse and deliver nothing.

## Interface
- NBIT, 8, width of delivered operand; accumulator is NBIT+4 bits wide.
- MAX_DIG, 3, maximum digit count per number; leading zeros count as digits.
- CLK  in  1  clock; all registers update on the rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- rx_empty  in  1  RX FIFO empty.
- rx_data  in  8  RX FIFO head (first-word-fall-through); valid while !rx_empty.
- RD_FIFO_IN  out  1  combinational pop strobe to the RX FIFO.
- dato_out  out  NBIT  parsed value; holds its last delivered value until the next delivery.
- dato_valid  out  1  registered; high while dato_out awaits ack.
- dato_ack  in  1  consumer accepts dato_out; sampled only while dato_valid=1.
- err  out  1  registered one-cycle pulse; a number was rejected.
- tx_full  in  1  TX FIFO full (echo path).
- WR_FIFO_OUT  out  1  echo write strobe.
- data_echo  out  8  echo character.

## Operation
- Registers: state, ch[7:0], acc[NBIT+3:0], cnt (digit count), malo (error flag), dato_out, dato_valid, err.
- Reset values: state=LEER; ch, acc, cnt, malo = 0; dato_out=0, dato_valid=0, err=0; RD_FIFO_IN=0, WR_FIFO_OUT=0, data_echo=0.
- LEER state:
  - If !rx_empty: RD_FIFO_IN=1, ch<=rx_data, next PROC.
  - Otherwise stay in LEER.
- PROC state (classifies ch):
  - Digit 0x30..0x39:
    - cnt==MAX_DIG -> malo<=1.
    - Else acc_next = (acc<<3)+(acc<<1)+(ch-0x30), computed at NBIT+4 bits (no wrap possible). If acc_next > 2^NBIT-1, malo<=1; else acc<=acc_next, cnt<=cnt+1.
    - Next LEER.
  - Terminator 0x0D, 0x0A or 0x20:
    - malo=1 -> err<=1, clear acc/cnt/malo, next LEER.
    - cnt==0 and malo=0 -> ignored (CR LF pair, repeated spaces), next LEER.
    - Otherwise dato_out<=acc[NBIT-1:0], dato_valid<=1, clear acc/cnt, next ESPERA.
  - Any other character -> malo<=1, next LEER. Characters are discarded until the next terminator.
- ESPERA state: no pops. When dato_ack=1: dato_valid<=0, next LEER.
- err is always cleared the cycle after it is set.
- Encoding: LEER=2'b00, PROC=2'b01, ESPERA=2'b10. Unused code 2'b11 -> LEER.

## Timing
- Each character costs 2 cycles: pop in LEER at cycle t, classify in PROC at t+1.
- Terminator popped at t: dato_valid=1 or err=1 visible at t+2.
- ack sampled at edge e: dato_valid=0 after e. The next pop occurs no earlier than the cycle after e, so the minimum number-to-number gap is 1 idle cycle.
- dato_ack while dato_valid=0: ignored.
- rx_empty during PROC has no effect; it is only checked in LEER.
- RESET mid-number: partial acc, cnt and malo are discarded and no err is issued. Any pending dato_valid drops immediately (asynchronous).

## Configuration
- INT_RX_ECHO_EN defined:
  - In the LEER pop cycle, if tx_full=0: WR_FIFO_OUT=1 and data_echo=rx_data, combinationally with RD_FIFO_IN.
  - If tx_full=1: the echo is dropped and parsing is unaffected.
- Undefined: WR_FIFO_OUT=0 and data_echo=0 at all times; ports remain present.

## Test plan
- "123\r", ack 3 cycles after valid -> dato_out=0x7B; dato_valid high at terminator pop+2, held until ack; err never asserted.
- "255\n" then "256\r" -> first delivers 0xFF; second gives err pulse, no dato_valid, dato_out stays 0xFF.
- "1a2 " and "0007\r" (MAX_DIG=3) -> err pulse for each, no valid; following "9\r" delivers 0x09.
- "\r\n  " then "42\r\n" -> the empty tokens produce nothing; 0x2A delivered once; trailing LF ignored.
- "12" followed by RESET pulse, then "5\r" -> 0x05 delivered, not 125; no err.
- INT_RX_ECHO_EN with tx_full=1 during the second char of "78\r" -> echo writes '7', '\r' only; dato_out=0x4E.

Source files
------------

// File: rtl/int_rx_dec.sv
// Decimal ASCII receiver: pops characters from the RX FIFO, parses terminated digit strings and
// hands out NBIT-bit operands under a valid/ack handshake. Optional echo path: INT_RX_ECHO_EN.
module int_rx_dec #(
  parameter int unsigned NBIT    = 8,
  parameter int unsigned MAX_DIG = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            rx_empty,
  input  logic [7:0]      rx_data,
  output logic            RD_FIFO_IN,
  output logic [NBIT-1:0] dato_out,
  output logic            dato_valid,
  input  logic            dato_ack,
  output logic            err,
  input  logic            tx_full,
  output logic            WR_FIFO_OUT,
  output logic [7:0]      data_echo
);

  localparam int unsigned AW = NBIT + 4;
  localparam int unsigned CW = $clog2(MAX_DIG + 1);
  localparam logic [AW-1:0] MaxVal = {4'b0000, {NBIT{1'b1}}};
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_DIG);

  typedef enum logic [1:0] {
    StLeer   = 2'b00,
    StProc   = 2'b01,
    StEspera = 2'b10
  } state_e;

  state_e          state_q;
  logic [7:0]      ch_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            malo_q;

  logic            is_digit;
  logic            is_term;
  logic [AW-1:0]   acc_d;
  logic            ovf;

  always_comb begin
    is_digit = (ch_q >= 8'h30) && (ch_q <= 8'h39);
    is_term  = (ch_q == 8'h0D) || (ch_q == 8'h0A) || (ch_q == 8'h20);
    // Accumulator is 4 bits wider than the operand, so acc*10+9 cannot wrap.
    acc_d    = (acc_q << 3) + (acc_q << 1) + {{(AW-4){1'b0}}, ch_q[3:0]};
    ovf      = acc_d > MaxVal;
  end

  assign RD_FIFO_IN = (state_q == StLeer) && !rx_empty && !RESET;

`ifdef INT_RX_ECHO_EN
  assign WR_FIFO_OUT = RD_FIFO_IN && !tx_full;
  assign data_echo   = WR_FIFO_OUT ? rx_data : 8'h00;
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign WR_FIFO_OUT    = 1'b0;
  assign data_echo      = 8'h00;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StLeer;
      ch_q       <= 8'h00;
      acc_q      <= '0;
      cnt_q      <= '0;
      malo_q     <= 1'b0;
      dato_out   <= '0;
      dato_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_q)
        StLeer: begin
          if (!rx_empty) begin
            ch_q    <= rx_data;
            state_q <= StProc;
          end
        end
        StProc: begin
          state_q <= StLeer;
          if (is_digit) begin
            if (cnt_q == MaxCnt || ovf) begin
              malo_q <= 1'b1;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (is_term) begin
            if (malo_q) begin
              err    <= 1'b1;
              acc_q  <= '0;
              cnt_q  <= '0;
              malo_q <= 1'b0;
            end else if (cnt_q != '0) begin
              dato_out   <= acc_q[NBIT-1:0];
              dato_valid <= 1'b1;
              acc_q      <= '0;
              cnt_q      <= '0;
              state_q    <= StEspera;
            end
          end else begin
            // Poison the token; everything up to the next terminator is discarded.
            malo_q <= 1'b1;
          end
        end
        StEspera: begin
          if (dato_ack) begin
            dato_valid <= 1'b0;
            state_q    <= StLeer;
          end
        end
        default: state_q <= StLeer;
      endcase
    end
  end

endmodule

// File: tb/tb_int_rx_dec.sv
// Self-checking bench for int_rx_dec: vector table, hand-written corner sequences and a random
// token stream checked against a token-level parser model.
module tb_int_rx_dec;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       RD_FIFO_IN;
  logic [7:0] dato_out;
  logic       dato_valid;
  logic       dato_ack = 1'b0;
  logic       err;
  logic       tx_full = 1'b0;
  logic       WR_FIFO_OUT;
  logic [7:0] data_echo;

  int_rx_dec #(.NBIT(8), .MAX_DIG(3)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .RD_FIFO_IN  (RD_FIFO_IN),
    .dato_out    (dato_out),
    .dato_valid  (dato_valid),
    .dato_ack    (dato_ack),
    .err         (err),
    .tx_full     (tx_full),
    .WR_FIFO_OUT (WR_FIFO_OUT),
    .data_echo   (data_echo)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       is_err;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    string      s;
    int         nval;
    int         nerr;
    logic [7:0] last;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         echo_bad = 0;
  int         proto_bad = 0;
  logic [7:0] rxq[$];
  logic [7:0] echoq[$];
  ev_t        evq[$];
  ev_t        expq[$];
  bit         auto_ack = 1'b1;
  bit         rand_mode = 1'b0;
  int         ack_dly = 1;
  int         ack_cnt = 0;
  int         full_at = -1;
  int         pop_idx = 0;
  int         term_pop_cyc = 0;
  int         first_valid_cyc = 0;
  int         valid_len = 0;
  bit         prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_term(input logic [7:0] c);
    return c == 8'h0D || c == 8'h0A || c == 8'h20;
  endfunction

  // Token-level reference: a token is accepted iff it is all digits, at most 3 long, <= 255.
  function automatic void model(input string s);
    int  len = 0;
    int  val = 0;
    bit  badch = 1'b0;
    ev_t e;
    for (int i = 0; i < s.len(); i++) begin
      if (is_term(s[i])) begin
        if (len > 0 || badch) begin
          e.is_err = badch || len > 3 || val > 255;
          e.val    = e.is_err ? 8'h00 : 8'(val);
          expq.push_back(e);
        end
        len = 0;
        val = 0;
        badch = 1'b0;
      end else if (s[i] >= "0" && s[i] <= "9") begin
        len++;
        if (len <= 3) val = val * 10 + (s[i] - "0");
      end else begin
        badch = 1'b1;
      end
    end
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
  endtask

  // One clock: drive inputs at the falling edge, sample after the next falling edge.
  task automatic tick();
    bit  stall;
    bit  pop;
    bit  exp_wr;
    ev_t e;
    stall    = rand_mode && ($urandom_range(3) == 0);
    rx_empty = stall || rxq.size() == 0;
    rx_data  = rx_empty ? 8'h00 : rxq[0];
    tx_full  = rand_mode ? 1'($urandom_range(1)) : (pop_idx == full_at);
    if (dato_valid && auto_ack) begin
      dato_ack = (ack_cnt >= ack_dly);
      ack_cnt++;
      if (dato_ack && rand_mode) ack_dly = $urandom_range(0, 3);
    end else begin
      dato_ack = rand_mode && ($urandom_range(3) == 0);
      ack_cnt  = 0;
    end
    #1;
    pop = RD_FIFO_IN;
    if (pop && rx_empty) proto_bad++;
`ifdef INT_RX_ECHO_EN
    exp_wr = pop && !tx_full;
    if (exp_wr && data_echo !== rx_data) echo_bad++;
`else
    exp_wr = 1'b0;
    if (data_echo !== 8'h00) echo_bad++;
`endif
    if (WR_FIFO_OUT !== exp_wr) echo_bad++;
    if (WR_FIFO_OUT === 1'b1) echoq.push_back(data_echo);
    @(posedge CLK);
    cyc++;
    if (pop && !rx_empty) begin
      if (is_term(rxq[0])) term_pop_cyc = cyc;
      void'(rxq.pop_front());
      pop_idx++;
    end
    @(negedge CLK);
    if (err === 1'b1) begin
      e.is_err = 1'b1;
      e.val = 8'h00;
      evq.push_back(e);
    end
    if (dato_valid && !prev_valid) begin
      e.is_err = 1'b0;
      e.val = dato_out;
      evq.push_back(e);
      first_valid_cyc = cyc;
      valid_len = 0;
    end
    if (dato_valid) valid_len++;
    prev_valid = dato_valid;
  endtask

  task automatic run_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      tick();
      n++;
      if (rxq.size() == 0 && !dato_valid && err !== 1'b1) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got %0d cycles expected idle within 3000", n);
    end
  endtask

  task automatic count_ev(output int nv, output int ne);
    nv = 0;
    ne = 0;
    foreach (evq[i]) if (evq[i].is_err) ne++; else nv++;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    #1;
    chk("rst_async_valid", dato_valid, 0);
    chk("rst_async_err", err, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    prev_valid = 1'b0;
  endtask

  vec_t vt[10];
  int   nv;
  int   ne;
  string tok;
  string stream;
  string exp_echo;

  initial begin
    vt[0] = '{"123\015", 1, 0, 8'h7B};
    vt[1] = '{"255\n", 1, 0, 8'hFF};
    vt[2] = '{"256\015", 0, 1, 8'hFF};
    vt[3] = '{"1a2 ", 0, 1, 8'hFF};
    vt[4] = '{"0007\015", 0, 1, 8'hFF};
    vt[5] = '{"9\015", 1, 0, 8'h09};
    vt[6] = '{"\015\n  ", 0, 0, 8'h09};
    vt[7] = '{"42\015\n", 1, 0, 8'h2A};
    vt[8] = '{"000 ", 1, 0, 8'h00};
    vt[9] = '{"x\015", 0, 1, 8'h00};

    // Reset state.
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_dato_out", dato_out, 0);
    chk("reset_dato_valid", dato_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_rd", RD_FIFO_IN, 0);
    chk("reset_wr", WR_FIFO_OUT, 0);
    chk("reset_echo", data_echo, 0);
    RESET = 1'b0;

    // "123\r" with ack 3 cycles after valid: latency and hold time.
    ack_dly = 3;
    evq.delete();
    push_str("123\015");
    run_idle();
    count_ev(nv, ne);
    chk("t123_nval", nv, 1);
    chk("t123_nerr", ne, 0);
    chk("t123_value", dato_out, 8'h7B);
    chk("t123_latency", first_valid_cyc - term_pop_cyc, 1);
    chk("t123_hold", valid_len, 4);

    // Vector table.
    ack_dly = 1;
    foreach (vt[i]) begin
      evq.delete();
      push_str(vt[i].s);
      run_idle();
      count_ev(nv, ne);
      chk($sformatf("vec%0d_nval", i), nv, vt[i].nval);
      chk($sformatf("vec%0d_nerr", i), ne, vt[i].nerr);
      chk($sformatf("vec%0d_dato", i), dato_out, 32'(vt[i].last));
    end

    // Pending valid dropped asynchronously by reset, then a partial number discarded.
    auto_ack = 1'b0;
    evq.delete();
    push_str("7\015");
    for (int i = 0; i < 20 && !dato_valid; i++) tick();
    chk("hold_valid_no_ack", dato_valid, 1);
    pulse_reset();
    chk("rst_dato_out", dato_out, 0);
    auto_ack = 1'b1;
    evq.delete();
    push_str("12");
    run_idle();
    pulse_reset();
    push_str("5\015");
    run_idle();
    count_ev(nv, ne);
    chk("rst_mid_nval", nv, 1);
    chk("rst_mid_nerr", ne, 0);
    chk("rst_mid_value", dato_out, 8'h05);

    // Echo with TX FIFO full during the second character.
    echoq.delete();
    pop_idx = 0;
    full_at = 1;
    push_str("78\015");
    run_idle();
    full_at = -1;
    chk("echo_dato", dato_out, 8'h4E);
`ifdef INT_RX_ECHO_EN
    exp_echo = "7\015";
`else
    exp_echo = "";
`endif
    chk("echo_count", echoq.size(), exp_echo.len());
    for (int i = 0; i < echoq.size() && i < exp_echo.len(); i++)
      chk($sformatf("echo_char%0d", i), echoq[i], exp_echo[i]);

    // Random token stream against the parser model.
    rand_mode = 1'b1;
    evq.delete();
    expq.delete();
    stream = "";
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0: tok = $sformatf("%03d", $urandom_range(0, 255));
        1: tok = $sformatf("%0d", $urandom_range(256, 999));
        2: tok = $sformatf("%04d", $urandom_range(0, 9999));
        3: tok = $sformatf("%0d%c%0d", $urandom_range(0, 99), $urandom_range(97, 122),
                           $urandom_range(0, 9));
        4: tok = "";
        default: tok = $sformatf("%0d", $urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 2))
        0: tok = {tok, "\015"};
        1: tok = {tok, "\n"};
        default: tok = {tok, " "};
      endcase
      stream = {stream, tok};
    end
    model(stream);
    push_str(stream);
    run_idle();
    chk("rand_nevents", evq.size(), expq.size());
    for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
      chk($sformatf("rand%0d_kind", i), evq[i].is_err, expq[i].is_err);
      if (!expq[i].is_err) chk($sformatf("rand%0d_val", i), evq[i].val, expq[i].val);
    end
    rand_mode = 1'b0;

    chk("echo_protocol", echo_bad, 0);
    chk("pop_protocol", proto_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
